// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for the RAM/IO target: bus width, I/O window decode and register offsets.
package ram_io_responder_pkg;

    localparam int BusWidth = 8;

    // I/O window lives where address bits [17:16] are both set.
    localparam logic [1:0] IoBase = 2'b11;
    // Register offsets inside the window, taken from address bits [2:0].
    localparam logic [2:0] IoUart = 3'd0;
    localparam logic [2:0] IoCtrl = 3'd4;

    typedef logic [BusWidth-1:0] byte_t;

    // Where a bus access lands.
    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_UART,
        ACC_CTRL,
        ACC_NONE
    } acc_e;

    // Classify an address: RAM outside the window, otherwise a register (or an unused hole).
    function automatic acc_e decode_addr(input logic [31:0] addr);
        acc_e acc;
        if (addr[17:16] != IoBase) begin
            acc = ACC_RAM;
        end else begin
            case (addr[2:0])
                IoUart:  acc = ACC_UART;
                IoCtrl:  acc = ACC_CTRL;
                default: acc = ACC_NONE;
            endcase
        end
        return acc;
    endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Circular byte FIFO with a registered almost-full flag that leaves MARGIN free slots.
module byte_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  byte_t                  i_data,
    input  logic                   i_pop,
    output byte_t                  o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    byte_t          r_buf [0:DEPTH-1];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_next;
    logic           r_almost_full;
    logic           w_push_ok;
    logic           w_pop_ok;

    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == CW'(DEPTH));
    assign o_count       = r_count;
    assign o_almost_full = r_almost_full;
    assign o_data        = r_buf[r_rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Storage writes; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_buf[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and the early-warning flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next >= CW'(DEPTH - MARGIN));
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-RAM bus target: read-first block RAM, console I/O registers and a TX FIFO with back-pressure.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_r_w,
    input  logic [31:0] ram_addr,
    input  logic [7:0]  ram_w_data,
    output logic [7:0]  ram_r_data,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        halt,
    output logic        tx_overflow
);

    acc_e                   w_acc;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic                   w_ram_we;
    byte_t                  w_io_rdata;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(TX_DEPTH):0] w_count;

    byte_t  r_mem [0:(1 << ADDR_WIDTH) - 1];
    byte_t  r_ram_q;
    byte_t  r_io_q;
    logic   r_sel_ram;
    logic   r_rx_pop;
    logic   r_halt;
    logic   r_tx_overflow;

    // Upper address bits are ignored, so RAM addresses alias.
    assign w_acc    = decode_addr(ram_addr);
    assign w_addr   = ram_addr[ADDR_WIDTH-1:0];
    assign w_ram_we = ram_r_w && (w_acc == ACC_RAM);
    assign w_push   = ram_r_w && (w_acc == ACC_UART);
    assign w_pop    = tx_valid && tx_ready;
    // A byte is lost only when full and nothing leaves this cycle.
    assign w_drop   = w_push && w_full && !w_pop;

    assign tx_valid       = (w_count != '0);
    assign ram_r_data     = r_sel_ram ? r_ram_q : r_io_q;
    assign rx_pop         = r_rx_pop;
    assign halt           = r_halt;
    assign tx_overflow    = r_tx_overflow;

    // Register read data for I/O reads; writes and unused offsets return zero.
    always_comb begin
        w_io_rdata = '0;
        if (!ram_r_w) begin
            case (w_acc)
                ACC_UART: w_io_rdata = rx_valid ? rx_data : '0;
                ACC_CTRL: w_io_rdata = {6'b0, tx_valid, rx_valid};
                default:  w_io_rdata = '0;
            endcase
        end
    end

    // Single-port read-first RAM: a write cycle still returns the old byte.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_addr] <= ram_w_data;
        end
        r_ram_q <= r_mem[w_addr];
    end

    // Output steering and I/O read side effects; reset forces the read bus to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_ram <= 1'b0;
            r_io_q    <= '0;
            r_rx_pop  <= 1'b0;
        end else begin
            r_sel_ram <= (w_acc == ACC_RAM);
            r_io_q    <= w_io_rdata;
            r_rx_pop  <= !ram_r_w && (w_acc == ACC_UART) && rx_valid;
        end
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt        <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            if (ram_r_w && (w_acc == ACC_CTRL)) begin
                r_halt <= 1'b1;
            end
            if (w_drop) begin
                r_tx_overflow <= 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH  (TX_DEPTH),
        .MARGIN (FULL_MARGIN)
    ) u_tx_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_data        (ram_w_data),
        .i_pop         (w_pop),
        .o_data        (tx_data),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_count       (w_count),
        .o_almost_full (io_buffer_full)
    );

    // The FIFO gates pops on emptiness itself; the flag is kept for visibility.
    logic w_empty_seen;
    assign w_empty_seen = w_empty;

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: models RAM, I/O registers and the TX FIFO.
module tb_ram_io_responder;

    localparam int TX_DEPTH    = 8;
    localparam int FULL_MARGIN = 2;

    logic        clk;
    logic        rst;
    logic        ram_r_w;
    logic [31:0] ram_addr;
    logic [7:0]  ram_w_data;
    logic [7:0]  ram_r_data;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        halt;
    logic        tx_overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl [int];
    logic [7:0] tq [$];
    logic [7:0] exp_q [$];
    logic       m_halt = 1'b0;
    logic       m_ovf  = 1'b0;

    ram_io_responder #(
        .ADDR_WIDTH  (17),
        .TX_DEPTH    (TX_DEPTH),
        .FULL_MARGIN (FULL_MARGIN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_r_w        (ram_r_w),
        .ram_addr       (ram_addr),
        .ram_w_data     (ram_w_data),
        .ram_r_data     (ram_r_data),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .halt           (halt),
        .tx_overflow    (tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, predict, let the edge happen, then score against the model.
    task automatic cyc(input logic rw, input logic [31:0] addr, input logic [7:0] wd);
        logic       io;
        logic [2:0] off;
        logic       pop;
        logic       acc;
        logic       have_exp;
        logic       exp_pop;
        logic [7:0] e;
        int         key;
        ram_r_w    = rw;
        ram_addr   = addr;
        ram_w_data = wd;
        io  = (addr[17:16] == 2'b11);
        off = addr[2:0];
        key = int'(addr[16:0]);
        if (tq.size() > 0) check("tx_data", tx_data, tq[0]);
        pop      = tx_ready && (tq.size() > 0);
        have_exp = 1'b0;
        exp_pop  = 1'b0;
        e        = 8'h00;
        if (io) begin
            have_exp = 1'b1;
            if (!rw) begin
                if (off == 3'd0) begin
                    e       = rx_valid ? rx_data : 8'h00;
                    exp_pop = rx_valid;
                end else if (off == 3'd4) begin
                    e = {6'b0, 1'(tq.size() > 0), rx_valid};
                end
            end
        end else if (mdl.exists(key)) begin
            have_exp = 1'b1;
            e        = mdl[key];
        end
        if (have_exp) exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rw && !io) mdl[key] = wd;
        if (rw && io && off == 3'd4) m_halt = 1'b1;
        acc = (tq.size() < TX_DEPTH) || pop;
        if (pop) void'(tq.pop_front());
        if (rw && io && off == 3'd0) begin
            if (acc) tq.push_back(wd);
            else m_ovf = 1'b1;
        end
        $display("txn rw=%0b addr=%05h wd=%02h rd=%02h txv=%0b full=%0b pop=%0b",
                 rw, addr, wd, ram_r_data, tx_valid, io_buffer_full, rx_pop);
        if (have_exp) check("rd_data", {24'b0, ram_r_data}, {24'b0, exp_q.pop_front()});
        check("rx_pop", rx_pop, exp_pop);
        check("halt", halt, m_halt);
        check("tx_overflow", tx_overflow, m_ovf);
        check("tx_valid", tx_valid, tq.size() > 0);
        check("buf_full", io_buffer_full, tq.size() >= TX_DEPTH - FULL_MARGIN);
    endtask

    // Reset with the bus still pointing at the current address, then verify reset values.
    task automatic do_reset();
        rst     = 1'b1;
        ram_r_w = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tq.delete();
        exp_q.delete();
        m_halt = 1'b0;
        m_ovf  = 1'b0;
        $display("txn reset rd=%02h txv=%0b full=%0b halt=%0b", ram_r_data, tx_valid, io_buffer_full, halt);
        check("rst_rd_data", ram_r_data, 0);
        check("rst_buf_full", io_buffer_full, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_pop", rx_pop, 0);
        check("rst_halt", halt, 0);
        check("rst_tx_overflow", tx_overflow, 0);
    endtask

    initial begin
        rst        = 1'b1;
        ram_r_w    = 1'b0;
        ram_addr   = 32'h0;
        ram_w_data = 8'h00;
        tx_ready   = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Write then read back, read-first overwrite, and aliasing above the array.
        cyc(1'b1, 32'h0_0010, 8'hA5);
        cyc(1'b0, 32'h0_0010, 8'h00);
        cyc(1'b0, 32'h2_0010, 8'h00);
        cyc(1'b1, 32'h0_0010, 8'h5A);
        cyc(1'b0, 32'h0_0010, 8'h00);

        // Streamed reads, one byte per cycle.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + i, 8'h11 * (i + 1));
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h100 + i, 8'h00);

        // Six pushes with the sink stalled raise the near-full flag, then drain in order.
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h3_0000, 8'hB0 + 8'(i));
        tx_ready = 1'b1;
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'h3_0004, 8'h00);

        // Full FIFO with a simultaneous pop still accepts the push.
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h3_0000, 8'hC0 + 8'(i));
        tx_ready = 1'b1;
        cyc(1'b1, 32'h3_0000, 8'hCF);
        for (int i = 0; i < 9; i++) cyc(1'b0, 32'h3_0004, 8'h00);

        // Ninth push into a stalled FIFO is dropped and flagged.
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'h3_0000, 8'hE0 + 8'(i));
        tx_ready = 1'b1;
        for (int i = 0; i < 9; i++) cyc(1'b0, 32'h3_0002, 8'h00);

        // Console input: data with pop when valid, zero without.
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        cyc(1'b0, 32'h3_0000, 8'h00);
        cyc(1'b0, 32'h0_0010, 8'h00);
        rx_valid = 1'b0;
        cyc(1'b0, 32'h3_0000, 8'h00);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        cyc(1'b0, 32'h3_0004, 8'h00);
        cyc(1'b1, 32'h3_0006, 8'h77);
        rx_valid = 1'b0;

        // Halt, fill a little, then reset in the middle of a read stream.
        tx_ready = 1'b0;
        cyc(1'b1, 32'h3_0004, 8'h00);
        cyc(1'b1, 32'h3_0000, 8'h91);
        cyc(1'b1, 32'h3_0000, 8'h92);
        cyc(1'b0, 32'h100, 8'h00);
        cyc(1'b0, 32'h101, 8'h00);
        ram_addr = 32'h102;
        do_reset();
        cyc(1'b0, 32'h103, 8'h00);
        cyc(1'b0, 32'h3_0004, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
